// File: rtl/acc_drain_bf16_seq.sv
// Accumulator tile drain sequencer: captures N_ACC int18 words on start and
// streams them in index order through one shared int18->bf16 normalizer.
module acc_drain_bf16_cvt #(
  parameter int FRAC_BITS = 8
) (
  input  logic [17:0] acc,
  output logic [15:0] bf
);
  logic        sign;
  logic [17:0] mag, norm;
  logic [4:0]  lz;
  logic        found;
  int          exp_i;

  always_comb begin
    sign  = acc[17];
    // -131072 negates to itself, which reads correctly as unsigned 0x20000
    mag   = sign ? (~acc + 18'd1) : acc;
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 17; i >= 0; i--) begin
      if (!found && mag[i]) begin
        lz    = 5'(17 - i);
        found = 1'b1;
      end
    end
    norm  = mag << lz;
    exp_i = 17 - int'(lz) - FRAC_BITS + 127;
    if (mag == 18'd0)     bf = 16'h0000;
    else if (exp_i <= 0)  bf = {sign, 15'b0};
    else if (exp_i >= 255) bf = {sign, 8'hFF, 7'b0};
    else                  bf = {sign, exp_i[7:0], norm[16:10]};
  end
endmodule

module acc_drain_bf16_seq #(
  parameter int N_ACC     = 4,
  parameter int FRAC_BITS = 8,
  parameter int IDX_W     = $clog2(N_ACC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  start_ready,
  input  logic [18*N_ACC-1:0]   acc_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [N_ACC-1:0][17:0]  buf_q, buf_d;
  logic [IDX_W-1:0]        rd_ptr_q, rd_ptr_d, nxt_ptr;
  logic [15:0]             out_data_q, out_data_d;
  logic [IDX_W-1:0]        out_idx_q, out_idx_d;
  logic                    out_valid_q, out_valid_d;
  logic                    done_q, done_d;
  logic [17:0]             cvt_in;
  logic [15:0]             cvt_out;
  logic                    hs, last;

  // In IDLE the converter looks straight at acc_in so word 0 is ready at capture
  assign nxt_ptr = rd_ptr_q + 1'b1;
  assign cvt_in  = (state_q == S_IDLE) ? acc_in[17:0] : buf_q[nxt_ptr];
  assign hs      = out_valid_q && out_ready;
  assign last    = (rd_ptr_q == IDX_W'(N_ACC - 1));

  acc_drain_bf16_cvt #(.FRAC_BITS(FRAC_BITS)) u_cvt (.acc(cvt_in), .bf(cvt_out));

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    rd_ptr_d    = rd_ptr_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          buf_d       = acc_in;
          rd_ptr_d    = '0;
          out_data_d  = cvt_out;
          out_idx_d   = '0;
          out_valid_d = 1'b1;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (hs) begin
          if (last) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else begin
            rd_ptr_d   = nxt_ptr;
            out_data_d = cvt_out;
            out_idx_d  = nxt_ptr;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q == S_DRAIN);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_idx     = out_idx_q;
  assign done        = done_q;
endmodule

// File: tb/tb_acc_drain_bf16_seq.sv
// Directed bench for acc_drain_bf16_seq: drives on negedge, samples on negedge
// before driving, expected bf16 values computed by hand.
module tb_acc_drain_bf16_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start_ready;
  logic [71:0] acc_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [1:0]  out_idx;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [71:0] tile_a = {18'h00180, 18'h00000, 18'h3FF00, 18'h00100};
  logic [71:0] tile_b = {18'h00001, 18'h00080, 18'h20000, 18'h1FFFF};
  logic [15:0] exp_a [4] = '{16'h3F80, 16'hBF80, 16'h0000, 16'h3FC0};
  logic [15:0] exp_b [4] = '{16'h43FF, 16'hC400, 16'h3F00, 16'h3B80};

  acc_drain_bf16_seq #(.N_ACC(4), .FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
    .acc_in(acc_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task test_reset;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({out_valid, out_data, out_idx, done, busy, start_ready} !== {1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got v=%b d=%h i=%0d done=%b busy=%b sr=%b, want 0/0000/0/0/0/1",
               out_valid, out_data, out_idx, done, busy, start_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task test_basic;
    start = 1'b1; acc_in = tile_a; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({out_valid, out_data, out_idx, busy, done} !== {1'b1, exp_a[i], 2'(i), 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL basic_word%0d: got v=%b d=%h i=%0d busy=%b done=%b, want 1/%h/%0d/1/0",
                 i, out_valid, out_data, out_idx, busy, done, exp_a[i], i);
      end
      @(negedge clk);
    end
    n_vec++;
    if ({done, out_valid, busy, start_ready} !== 4'b1001) begin
      n_err++;
      $display("FAIL basic_done: got done=%b v=%b busy=%b sr=%b, want 1/0/0/1", done, out_valid, busy, start_ready);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_pulse: got done=%b want 0", done);
    end
  endtask

  task test_extremes;
    start = 1'b1; acc_in = tile_b; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({out_valid, out_data, out_idx} !== {1'b1, exp_b[i], 2'(i)}) begin
        n_err++;
        $display("FAIL extreme_word%0d: got v=%b d=%h i=%0d, want 1/%h/%0d",
                 i, out_valid, out_data, out_idx, exp_b[i], i);
      end
      @(negedge clk);
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL extreme_done: got %b want 1", done);
    end
    @(negedge clk);
  endtask

  task test_backpressure;
    logic [6:0] pat;
    int cnt, dones;
    pat = 7'b1110100;
    cnt = 0; dones = 0;
    start = 1'b1; acc_in = tile_a; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) dones++;
      n_vec++;
      if (cnt < 4) begin
        if ({out_valid, out_data, out_idx} !== {1'b1, exp_a[cnt], 2'(cnt)}) begin
          n_err++;
          $display("FAIL bp_cycle%0d: got v=%b d=%h i=%0d, want 1/%h/%0d",
                   c, out_valid, out_data, out_idx, exp_a[cnt], cnt);
        end
      end else if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL bp_cycle%0d_idle: got v=%b want 0", c, out_valid);
      end
      out_ready = (c < 7) ? pat[c] : 1'b1;
      if (out_valid === 1'b1 && out_ready) cnt++;
      @(negedge clk);
    end
    n_vec++;
    if (cnt != 4 || dones != 1) begin
      n_err++;
      $display("FAIL bp_counts: got handshakes=%0d dones=%0d, want 4/1", cnt, dones);
    end
  endtask

  task test_start_ignored;
    start = 1'b1; acc_in = tile_a; out_ready = 1'b1;
    @(negedge clk);
    acc_in = tile_b;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) start = 1'b0;
      n_vec++;
      if ({out_valid, out_data, out_idx, start_ready} !== {1'b1, exp_a[i], 2'(i), 1'b0}) begin
        n_err++;
        $display("FAIL ignore_word%0d: got v=%b d=%h i=%0d sr=%b, want 1/%h/%0d/0",
                 i, out_valid, out_data, out_idx, start_ready, exp_a[i], i);
      end
      @(negedge clk);
    end
    n_vec++;
    if ({done, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL ignore_done: got done=%b v=%b want 1/0", done, out_valid);
    end
    @(negedge clk);
  endtask

  task test_back_to_back;
    start = 1'b1; acc_in = tile_a; out_ready = 1'b1;
    @(negedge clk);
    acc_in = tile_b;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({out_valid, out_data, out_idx} !== {1'b1, exp_a[i], 2'(i)}) begin
        n_err++;
        $display("FAIL b2b_a%0d: got v=%b d=%h i=%0d, want 1/%h/%0d", i, out_valid, out_data, out_idx, exp_a[i], i);
      end
      @(negedge clk);
    end
    n_vec++;
    if ({done, out_valid, start_ready} !== 3'b101) begin
      n_err++;
      $display("FAIL b2b_gap: got done=%b v=%b sr=%b want 1/0/1", done, out_valid, start_ready);
    end
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({out_valid, out_data, out_idx} !== {1'b1, exp_b[i], 2'(i)}) begin
        n_err++;
        $display("FAIL b2b_b%0d: got v=%b d=%h i=%0d, want 1/%h/%0d", i, out_valid, out_data, out_idx, exp_b[i], i);
      end
      @(negedge clk);
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done2: got %b want 1", done);
    end
    @(negedge clk);
  endtask

  task test_reset_mid;
    int dones;
    dones = 0;
    start = 1'b1; acc_in = tile_a; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_data, out_idx, done, busy, start_ready} !== {1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL midreset_state: got v=%b d=%h i=%0d done=%b busy=%b sr=%b, want 0/0000/0/0/0/1",
               out_valid, out_data, out_idx, done, busy, start_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0 || out_valid !== 1'b0) dones++;
    end
    n_vec++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL midreset_quiet: got %0d active cycles want 0", dones);
    end
    start = 1'b1; acc_in = tile_b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({out_valid, out_data, out_idx} !== {1'b1, exp_b[i], 2'(i)}) begin
        n_err++;
        $display("FAIL midreset_word%0d: got v=%b d=%h i=%0d, want 1/%h/%0d",
                 i, out_valid, out_data, out_idx, exp_b[i], i);
      end
      @(negedge clk);
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_done: got %b want 1", done);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_extremes;
    test_backpressure;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
